// File: rtl/cfg_frame_pkg.sv
// Shared types and constants for the configuration frame assembler.
// CFG_FRAME_CHECKSUM_EN adds a trailing XOR checksum word to every frame.
package cfg_frame_pkg;

    typedef enum logic [1:0] {
        ST_DESYNCED = 2'd0,
        ST_ADDRESS  = 2'd1,
        ST_DATA     = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

    localparam int COLUMN_LSB   = 8;
    localparam int COLUMN_MSB   = 15;
    localparam int COLUMN_WIDTH = COLUMN_MSB - COLUMN_LSB + 1;

`ifdef CFG_FRAME_CHECKSUM_EN
    localparam int CHECKSUM_WORDS = 1;
`else
    localparam int CHECKSUM_WORDS = 0;
`endif

endpackage

// File: rtl/frame_select_decoder.sv
// Combinational column/index to one-hot frame select decoder with range check.
module frame_select_decoder
    import cfg_frame_pkg::*;
#(
    parameter int NUMBER_OF_COLS     = 5,
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int FRAME_SELECT_WIDTH = 5
) (
    input  logic [COLUMN_WIDTH-1:0]                       column,
    input  logic [FRAME_SELECT_WIDTH-1:0]                 index,
    input  logic                                          enable,
    output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0]  select,
    output logic                                          out_of_range
);

    assign out_of_range = (int'(column) >= NUMBER_OF_COLS) ||
                          (int'(index) >= MAX_FRAMES_PER_COL);

    // Each select bit matches its own (column, index) pair, avoiding a wide multiplier.
    for (genvar gi = 0; gi < MAX_FRAMES_PER_COL * NUMBER_OF_COLS; gi++) begin : g_sel
        assign select[gi] = enable && !out_of_range &&
                            (int'(column) == gi / MAX_FRAMES_PER_COL) &&
                            (int'(index) == gi % MAX_FRAMES_PER_COL);
    end

endmodule

// File: rtl/config_frame_assembler.sv
// Parses the self-write configuration word stream into row frames and commits them
// with a one-cycle strobe. Optional macro: CFG_FRAME_CHECKSUM_EN.
module config_frame_assembler
    import cfg_frame_pkg::*;
#(
    parameter int          NUMBER_OF_ROWS     = 4,
    parameter int          NUMBER_OF_COLS     = 5,
    parameter int          FRAME_BITS_PER_ROW = 32,
    parameter int          MAX_FRAMES_PER_COL = 20,
    parameter int          DESYNC_FLAG        = 20,
    parameter int          FRAME_SELECT_WIDTH = 5,
    parameter logic [31:0] SYNC_WORD          = DEFAULT_SYNC_WORD
) (
    input  logic                                          clk_system_i,
    input  logic                                          reset_i,
    input  logic [31:0]                                   write_data_i,
    input  logic                                          write_strobe_i,
    output logic [NUMBER_OF_ROWS*32-1:0]                  frame_data_o,
    output logic [MAX_FRAMES_PER_COL*NUMBER_OF_COLS-1:0]  frame_select_o,
    output logic                                          frame_strobe_o,
    output logic                                          synced_o,
    output logic                                          error_o
);

    localparam int SEL_W     = MAX_FRAMES_PER_COL * NUMBER_OF_COLS;
    localparam int DATA_W    = NUMBER_OF_ROWS * 32;
    localparam int LAST_WORD = NUMBER_OF_ROWS - 1 + CHECKSUM_WORDS;
    localparam int CNT_W     = (LAST_WORD > 0) ? $clog2(LAST_WORD + 1) : 1;

    if (FRAME_BITS_PER_ROW != 32) begin : g_bad_row_width
        $error("config_frame_assembler: FRAME_BITS_PER_ROW must be 32");
    end

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   row_cnt_reg, row_cnt_next;
    logic               valid_reg, valid_next;
    logic [SEL_W-1:0]   pending_sel_reg, pending_sel_next;
    logic [DATA_W-1:0]  shadow_reg, shadow_next;
    logic [DATA_W-1:0]  frame_data_reg, frame_data_next;
    logic [SEL_W-1:0]   select_reg, select_next;
    logic               strobe_reg, strobe_next;
    logic               error_reg, error_next;
    logic               commit_ok;
`ifdef CFG_FRAME_CHECKSUM_EN
    logic [31:0]        checksum_reg, checksum_next;
`endif

    logic [SEL_W-1:0]   word_select;
    logic               word_out_of_range;

    // Decode straight from the incoming address word so the select is ready before any data arrives.
    frame_select_decoder #(
        .NUMBER_OF_COLS     (NUMBER_OF_COLS),
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL),
        .FRAME_SELECT_WIDTH (FRAME_SELECT_WIDTH)
    ) u_select_decoder (
        .column       (write_data_i[COLUMN_MSB:COLUMN_LSB]),
        .index        (write_data_i[FRAME_SELECT_WIDTH-1:0]),
        .enable       (write_strobe_i && (state_reg == ST_ADDRESS)),
        .select       (word_select),
        .out_of_range (word_out_of_range)
    );

    always_comb begin
        state_next       = state_reg;
        row_cnt_next     = row_cnt_reg;
        valid_next       = valid_reg;
        pending_sel_next = pending_sel_reg;
        shadow_next      = shadow_reg;
        frame_data_next  = frame_data_reg;
        select_next      = '0;
        strobe_next      = 1'b0;
        error_next       = error_reg;
        commit_ok        = 1'b0;
`ifdef CFG_FRAME_CHECKSUM_EN
        checksum_next    = checksum_reg;
`endif
        if (write_strobe_i) begin
            case (state_reg)
                ST_DESYNCED: begin
                    if (write_data_i == SYNC_WORD) begin
                        state_next = ST_ADDRESS;
                        error_next = 1'b0;
                    end
                end
                ST_ADDRESS: begin
                    if (write_data_i[DESYNC_FLAG]) begin
                        state_next = ST_DESYNCED;
                    end else begin
                        state_next       = ST_DATA;
                        row_cnt_next     = '0;
                        valid_next       = !word_out_of_range;
                        pending_sel_next = word_select;
                        if (word_out_of_range)
                            error_next = 1'b1;
`ifdef CFG_FRAME_CHECKSUM_EN
                        checksum_next = write_data_i;
`endif
                    end
                end
                ST_DATA: begin
                    for (int r = 0; r < NUMBER_OF_ROWS; r++) begin
                        if (int'(row_cnt_reg) == r)
                            shadow_next[r*32 +: 32] = write_data_i;
                    end
                    row_cnt_next = row_cnt_reg + 1'b1;
`ifdef CFG_FRAME_CHECKSUM_EN
                    checksum_next = checksum_reg ^ write_data_i;
`endif
                    if (int'(row_cnt_reg) == LAST_WORD) begin
                        state_next = ST_ADDRESS;
`ifdef CFG_FRAME_CHECKSUM_EN
                        commit_ok = valid_reg && (write_data_i == checksum_reg);
                        if (write_data_i != checksum_reg)
                            error_next = 1'b1;
`else
                        commit_ok = valid_reg;
`endif
                        if (commit_ok) begin
                            strobe_next     = 1'b1;
                            select_next     = pending_sel_reg;
                            frame_data_next = shadow_next;
                        end
                    end
                end
                default: state_next = ST_DESYNCED;
            endcase
        end
    end

    always_ff @(posedge clk_system_i) begin
        if (reset_i) begin
            state_reg       <= ST_DESYNCED;
            row_cnt_reg     <= '0;
            valid_reg       <= 1'b0;
            pending_sel_reg <= '0;
            shadow_reg      <= '0;
            frame_data_reg  <= '0;
            select_reg      <= '0;
            strobe_reg      <= 1'b0;
            error_reg       <= 1'b0;
`ifdef CFG_FRAME_CHECKSUM_EN
            checksum_reg    <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            row_cnt_reg     <= row_cnt_next;
            valid_reg       <= valid_next;
            pending_sel_reg <= pending_sel_next;
            shadow_reg      <= shadow_next;
            frame_data_reg  <= frame_data_next;
            select_reg      <= select_next;
            strobe_reg      <= strobe_next;
            error_reg       <= error_next;
`ifdef CFG_FRAME_CHECKSUM_EN
            checksum_reg    <= checksum_next;
`endif
        end
    end

    assign frame_data_o   = frame_data_reg;
    assign frame_select_o = select_reg;
    assign frame_strobe_o = strobe_reg;
    assign synced_o       = (state_reg != ST_DESYNCED);
    assign error_o        = error_reg;

endmodule

// File: tb/tb_config_frame_assembler.sv
// Scoreboard bench for config_frame_assembler: expected commits are queued as frames
// are driven and matched against each frame strobe.
module tb_config_frame_assembler;

    localparam int ROWS   = 4;
    localparam int COLS   = 5;
    localparam int FRAMES = 20;
    localparam int SEL_W  = COLS * FRAMES;
    localparam int DATA_W = ROWS * 32;
    localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

    typedef struct {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    logic              clk_system_i = 1'b0;
    logic              reset_i;
    logic [31:0]       write_data_i;
    logic              write_strobe_i;
    logic [DATA_W-1:0] frame_data_o;
    logic [SEL_W-1:0]  frame_select_o;
    logic              frame_strobe_o;
    logic              synced_o;
    logic              error_o;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] last_data = '0;
    int                checks = 0;
    int                errors = 0;
    int                cycle_cnt = 0;
    bit                mon_en = 1'b0;

    config_frame_assembler dut (
        .clk_system_i   (clk_system_i),
        .reset_i        (reset_i),
        .write_data_i   (write_data_i),
        .write_strobe_i (write_strobe_i),
        .frame_data_o   (frame_data_o),
        .frame_select_o (frame_select_o),
        .frame_strobe_o (frame_strobe_o),
        .synced_o       (synced_o),
        .error_o        (error_o)
    );

    always #5 clk_system_i = ~clk_system_i;
    always @(posedge clk_system_i) cycle_cnt <= cycle_cnt + 1;

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        write_data_i   = w;
        write_strobe_i = 1'b1;
        @(posedge clk_system_i);
        #1;
        write_strobe_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_system_i);
        #1;
    endtask

    // Drives address, rows and (if built in) checksum; queues the commit the bench expects.
    task automatic send_frame(input logic [31:0] addr, input logic [DATA_W-1:0] rows, input bit bad_sum);
        logic [31:0] sum;
        int col, idx;
        bit in_range;
        exp_t e;
        col = int'(addr[15:8]);
        idx = int'(addr[4:0]);
        in_range = (col < COLS) && (idx < FRAMES);
        sum = addr;
        send_word(addr);
        for (int k = 0; k < ROWS; k++) begin
            send_word(rows[k*32 +: 32]);
            sum ^= rows[k*32 +: 32];
        end
`ifdef CFG_FRAME_CHECKSUM_EN
        send_word(bad_sum ? (sum ^ 32'd1) : sum);
`endif
        if (in_range && !bad_sum) begin
            e.sel = '0;
            e.sel[col*FRAMES + idx] = 1'b1;
            e.data = rows;
            e.cyc = cycle_cnt;
            exp_q.push_back(e);
            last_data = rows;
        end
    endtask

    always @(negedge clk_system_i) begin
        if (mon_en) begin
            if (frame_strobe_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 128'(frame_select_o), 128'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("frame strobe at cycle %0d select %h data %h", cycle_cnt, frame_select_o, frame_data_o);
                    check("strobe_latency", 128'(cycle_cnt), 128'(e.cyc));
                    check("frame_select", 128'(frame_select_o), 128'(e.sel));
                    check("frame_data", frame_data_o, e.data);
                end
            end else begin
                check("select_idle", 128'(frame_select_o), 128'd0);
            end
        end
    end

    initial begin
        reset_i        = 1'b1;
        write_data_i   = '0;
        write_strobe_i = 1'b0;
        repeat (3) @(posedge clk_system_i);
        #1;
        reset_i = 1'b0;
        check("rst_strobe", 128'(frame_strobe_o), 128'd0);
        check("rst_select", 128'(frame_select_o), 128'd0);
        check("rst_data", frame_data_o, 128'd0);
        check("rst_synced", 128'(synced_o), 128'd0);
        check("rst_error", 128'(error_o), 128'd0);
        mon_en = 1'b1;

        // Words before any sync are ignored.
        send_word(32'h1234_5678);
        send_word(32'h0000_0203);
        idle(2);
        check("presync_synced", 128'(synced_o), 128'd0);

        // Basic frame, then back-to-back frames whose address coincides with the previous strobe.
        send_word(SYNC);
        check("sync_synced", 128'(synced_o), 128'd1);
        send_frame(32'h0000_0203, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 1'b0);
        send_frame(32'h0000_0113, {32'hDEAD_BEEF, 32'h0BAD_F00D, 32'hCAFE_0001, 32'h5555_AAAA}, 1'b0);
        send_frame(32'hFF0E_0400, {32'h0000_0004, SYNC, 32'h0000_0002, 32'h0000_0001}, 1'b0);
        idle(2);
        check("basic_data_hold", frame_data_o, last_data);
        check("basic_synced", 128'(synced_o), 128'd1);
        check("basic_error", 128'(error_o), 128'd0);

        // Out-of-range column and index: consumed, flagged, not committed.
        send_frame(32'h0000_0500, {32'hA0A0_A0A0, 32'hB0B0_B0B0, 32'hC0C0_C0C0, 32'hD0D0_D0D0}, 1'b0);
        idle(1);
        check("oor_col_error", 128'(error_o), 128'd1);
        send_frame(32'h0000_0014, {32'h1, 32'h2, 32'h3, 32'h4}, 1'b0);
        idle(1);
        check("oor_data_hold", frame_data_o, last_data);
        send_frame(32'h0000_0313, {32'h7777_0000, 32'h6666_0000, 32'h5555_0000, 32'h4444_0000}, 1'b0);
        idle(2);
        check("oor_error_sticky", 128'(error_o), 128'd1);

        // Desync, then ignored data, then resync clears the error flag.
        send_word(32'h0010_0000);
        idle(1);
        check("desync_synced", 128'(synced_o), 128'd0);
        for (int k = 0; k < ROWS; k++) send_word(32'h0000_0203 + k);
        idle(2);
        check("desync_error_kept", 128'(error_o), 128'd1);
        send_word(SYNC);
        check("resync_error_clr", 128'(error_o), 128'd0);
        check("resync_synced", 128'(synced_o), 128'd1);

        // Reset partway through a frame discards it.
        send_word(32'h0000_0001);
        send_word(32'h9999_0001);
        send_word(32'h9999_0002);
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        check("midrst_strobe", 128'(frame_strobe_o), 128'd0);
        check("midrst_data", frame_data_o, 128'd0);
        check("midrst_synced", 128'(synced_o), 128'd0);
        check("midrst_error", 128'(error_o), 128'd0);
        last_data = '0;
        send_word(SYNC);
        send_frame(32'h0000_0001, {32'h9999_0004, 32'h9999_0003, 32'h9999_0002, 32'h9999_0001}, 1'b0);
        idle(2);
        check("resend_data", frame_data_o, last_data);

`ifdef CFG_FRAME_CHECKSUM_EN
        send_frame(32'h0000_0102, {32'h1357_9BDF, 32'h2468_ACE0, 32'hFFFF_0000, 32'h0F0F_0F0F}, 1'b0);
        idle(1);
        check("csum_ok_error", 128'(error_o), 128'd0);
        send_frame(32'h0000_0102, {32'h1, 32'h1, 32'h1, 32'h1}, 1'b1);
        idle(2);
        check("csum_bad_error", 128'(error_o), 128'd1);
        check("csum_bad_hold", frame_data_o, last_data);
`endif

        idle(4);
        check("pending_frames", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
